// File: rtl/addsub_pipe.sv
// Segmented pipelined adder/subtractor: each stage adds SEG bits and forwards its carry,
// with a valid/ready handshake that freezes the whole pipeline while the output is stalled.
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NSEG = WIDTH / SEG;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    op_e              op_dec;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             stall;
    logic             advance;

    assign op_dec = op_e'(op);

    always_comb begin
        b_eff = inB;
        c0    = 1'b0;
        case (op_dec)
            OP_ADD: begin b_eff = inB;  c0 = 1'b0; end
            OP_SUB: begin b_eff = ~inB; c0 = 1'b1; end
            OP_ADC: begin b_eff = inB;  c0 = cin;  end
            OP_SBB: begin b_eff = ~inB; c0 = ~cin; end
            default: ;
        endcase
    end

    // A single global enable keeps bubbles and data moving in lockstep, so order is preserved.
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~reset_n | ~stall;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        // SRC_W: operand bits not yet consumed entering this stage; DONE_W: sum bits finished after it.
        localparam int SRC_W  = WIDTH - k * SEG;
        localparam int DONE_W = (k + 1) * SEG;

        logic [SRC_W-1:0]  a_src, b_src;
        logic              c_src, v_src, am_src, bm_src;
        logic [TAG_W-1:0]  tag_src;
        logic [SEG-1:0]    seg_sum;
        logic              seg_cout;

        logic              valid_d, valid_q;
        logic              carry_d, carry_q;
        logic              a_msb_d, a_msb_q;
        logic              b_msb_d, b_msb_q;
        logic [TAG_W-1:0]  tag_d, tag_q;
        logic [DONE_W-1:0] sum_d, sum_q;

        if (k == 0) begin : g_src
            assign a_src   = inA;
            assign b_src   = b_eff;
            assign c_src   = c0;
            assign v_src   = in_valid;
            assign tag_src = in_tag;
            assign am_src  = inA[WIDTH-1];
            assign bm_src  = b_eff[WIDTH-1];
            always_comb sum_d = seg_sum;
        end else begin : g_src
            assign a_src   = g_stage[k-1].g_rem.a_q;
            assign b_src   = g_stage[k-1].g_rem.b_q;
            assign c_src   = g_stage[k-1].carry_q;
            assign v_src   = g_stage[k-1].valid_q;
            assign tag_src = g_stage[k-1].tag_q;
            assign am_src  = g_stage[k-1].a_msb_q;
            assign bm_src  = g_stage[k-1].b_msb_q;
            always_comb sum_d = {seg_sum, g_stage[k-1].sum_q};
        end

        assign {seg_cout, seg_sum} = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]}
                                   + {{SEG{1'b0}}, c_src};

        always_comb begin
            valid_d = v_src;
            carry_d = seg_cout;
            a_msb_d = am_src;
            b_msb_d = bm_src;
            tag_d   = tag_src;
        end

        always_ff @(posedge clock) begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples the
            // previous stage's old value on the same edge; blocking here would collapse the pipe.
            if (!reset_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                a_msb_q <= 1'b0;
                b_msb_q <= 1'b0;
                tag_q   <= '0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                a_msb_q <= a_msb_d;
                b_msb_q <= b_msb_d;
                tag_q   <= tag_d;
                sum_q   <= sum_d;
            end
        end

        if (k < NSEG - 1) begin : g_rem
            logic [SRC_W-SEG-1:0] a_d, a_q, b_d, b_q;

            always_comb begin
                a_d = a_src[SRC_W-1:SEG];
                b_d = b_src[SRC_W-1:SEG];
            end

            // NOTE: the unconsumed operand bits are pure datapath qualified by valid_q, so they
            // carry no reset; only control and the visible result registers are cleared.
            always_ff @(posedge clock) begin
                if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].valid_q;
    assign sum       = g_stage[NSEG-1].sum_q;
    assign cout      = g_stage[NSEG-1].carry_q;
    assign out_tag   = g_stage[NSEG-1].tag_q;
    assign neg       = sum[WIDTH-1];
    // Gated by out_valid so the flag reads 0 out of reset rather than reporting the cleared sum.
    assign zero      = out_valid & ~|sum;
    assign ovf       = (g_stage[NSEG-1].a_msb_q == g_stage[NSEG-1].b_msb_q)
                     & (sum[WIDTH-1] != g_stage[NSEG-1].a_msb_q);

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: table of hand-computed vectors plus stall and
// mid-flight reset sequences.
module tb_addsub_pipe;

    localparam int NV = 15;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inA, inB;
    logic [1:0]  op;
    logic        cin;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout, ovf, zero, neg;
    logic [3:0]  out_tag;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [NV];

    always #5 clock = ~clock;

    addsub_pipe #(.WIDTH(32), .SEG(8), .TAG_W(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inA       (inA),
        .inB       (inB),
        .op        (op),
        .cin       (cin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_op(input int i, input logic [3:0] tag);
        in_valid = 1'b1;
        inA      = vecs[i].a;
        inB      = vecs[i].b;
        op       = vecs[i].op;
        cin      = vecs[i].cin;
        in_tag   = tag;
    endtask

    task automatic check_result(input int i, input logic [3:0] tag);
        logic [31:0] s;
        s = vecs[i].s;
        check($sformatf("v%0d sum", i),  sum,  s);
        check($sformatf("v%0d cout", i), cout, vecs[i].co);
        check($sformatf("v%0d ovf", i),  ovf,  vecs[i].ov);
        check($sformatf("v%0d zero", i), zero, (s == 32'h0));
        check($sformatf("v%0d neg", i),  neg,  s[31]);
        check($sformatf("v%0d tag", i),  out_tag, tag);
    endtask

    // One isolated operation: measures latency to out_valid, then checks the result.
    task automatic run_single(input int i, input logic [3:0] tag);
        int lat;
        @(negedge clock);
        out_ready = 1'b1;
        drive_op(i, tag);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        check($sformatf("v%0d latency", i), lat, 4);
        if (out_valid) check_result(i, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          idx;
        int          n_out;
        int          exp_tag;
        logic        seen;

        //          a             b             op     cin   sum           cout  ovf
        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{32'h00000000, 32'h00000001, 2'b01, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000005, 32'h00000003, 2'b11, 1'b1, 32'h00000001, 1'b1, 1'b0};
        vecs[4]  = '{32'h00000010, 32'h00000020, 2'b10, 1'b1, 32'h00000031, 1'b0, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'h00000000, 2'b10, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{32'h80000000, 32'h00000001, 2'b01, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[7]  = '{32'h00000005, 32'h00000003, 2'b11, 1'b0, 32'h00000002, 1'b1, 1'b0};
        vecs[8]  = '{32'h12345678, 32'h9ABCDEF0, 2'b00, 1'b0, 32'hACF13568, 1'b0, 1'b0};
        vecs[9]  = '{32'h00000005, 32'h00000005, 2'b01, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{32'h80000000, 32'h80000000, 2'b00, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[12] = '{32'h00000001, 32'h00000001, 2'b00, 1'b1, 32'h00000002, 1'b0, 1'b0};
        vecs[13] = '{32'h0000000A, 32'h00000003, 2'b01, 1'b1, 32'h00000007, 1'b1, 1'b0};
        vecs[14] = '{32'h000000FF, 32'h00000001, 2'b00, 1'b0, 32'h00000100, 1'b0, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inA       = '0;
        inB       = '0;
        op        = 2'b00;
        cin       = 1'b0;
        in_tag    = '0;

        // Reset state, with the consumer not ready.
        repeat (2) @(negedge clock);
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready",  in_ready,  1'b1);
        check("rst sum",       sum,       32'h0);
        check("rst cout",      cout,      1'b0);
        check("rst ovf",       ovf,       1'b0);
        check("rst zero",      zero,      1'b0);
        check("rst neg",       neg,       1'b0);
        check("rst out_tag",   out_tag,   4'h0);
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // Isolated vectors: latency and every output field.
        for (int i = 0; i < NV; i++) run_single(i, 4'(i));

        // Eight back-to-back ops, consumer stalls in cycles 5..7.
        idx     = 0;
        n_out   = 0;
        exp_tag = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clock);
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (idx < 8) drive_op(idx, 4'(idx));
            else in_valid = 1'b0;
            #1;
            check($sformatf("bb c%0d in_ready", cyc), in_ready, !(cyc >= 5 && cyc <= 7));
            if (cyc >= 5 && cyc <= 7) begin
                check($sformatf("bb c%0d held valid", cyc), out_valid, 1'b1);
                check($sformatf("bb c%0d held tag", cyc), out_tag, 4'd1);
                check($sformatf("bb c%0d held sum", cyc), sum, vecs[1].s);
            end
            if (out_valid && out_ready) begin
                if (exp_tag < 8) check_result(exp_tag, 4'(exp_tag));
                else check("bb extra result", out_tag, 4'hF);
                exp_tag++;
                n_out++;
            end
            if (in_valid && in_ready) idx++;
        end
        check("bb result count", n_out, 8);

        // Reset with three ops in flight.
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive_op(8 + c, 4'(8 + c));
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("mid-rst in_ready", in_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        check("post-rst out_valid", out_valid, 1'b0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        check("flushed ops reappeared", seen, 1'b0);
        run_single(3, 4'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
